// File: rtl/serial_adder_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one bit per RUN cycle, LSB first, through a single full adder.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic             sum;
   logic             cout;
   logic [WIDTH-1:0] final_res;

   full_adder u_fa (
      .a    (a_reg[0]),
      .b    (b_reg[0]),
      .cin  (cy),
      .sum  (sum),
      .cout (cout)
   );

   // Value of the shift register once the MSB sum bit lands.
   assign final_res = {sum, sh[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         sh       <= '0;
         cnt      <= '0;
         cy       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtract is a + ~b + 1: invert B and seed the carry with 1.
                  a_reg <= a;
                  b_reg <= (op == OP_ADD) ? b : ~b;
                  cy    <= (op == OP_SUB);
                  cnt   <= '0;
                  sh    <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_reg <= a_reg >> 1;
               b_reg <= b_reg >> 1;
               sh    <= final_res;
               cy    <= cout;
               if (cnt == LAST) begin
                  // Outputs change only here so no partial result is ever visible.
                  result   <= final_res;
                  carry    <= cout;
                  overflow <= cy ^ cout;
                  zero     <= (final_res == '0);
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
